// File: rtl/mem_pkg.sv
// Shared definitions for the memory-port controller: width encodings, FSM states
// and the wait-counter width.
package mem_pkg;

    localparam logic [1:0] WIDTH_64 = 2'd0;
    localparam logic [1:0] WIDTH_32 = 2'd1;
    localparam logic [1:0] WIDTH_16 = 2'd2;
    localparam logic [1:0] WIDTH_8  = 2'd3;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_req_slot.sv
// One request latch: captures a strobe into a pending slot and holds it until the
// controller pulses clear on completion.
module mem_req_slot
    import mem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rstrobe,
    input  logic              wstrobe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        width,
    input  logic              clear,
    output logic              pending,
    output logic              is_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [1:0]        req_width
);

    logic strobe;
    logic free;

    assign strobe = rstrobe || wstrobe;
    // A slot completing this cycle is already free to accept the next strobe.
    assign free   = !pending || clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            is_write  <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_width <= WIDTH_64;
        end else if (free) begin
            pending <= strobe;
            if (strobe) begin
                is_write  <= wstrobe;
                req_addr  <= addr;
                req_wdata <= wdata;
                req_width <= width;
            end
        end
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Fixed-priority arbiter of strobe-style requesters onto one synchronous RAM port.
// Optional address bounds check is enabled by defining MEMCTRL_BOUNDS_CHK_EN.
module mem_port_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int NUM_PORTS   = 2,
    parameter int WAIT_STATES = 0,
    parameter int NUM_BYTES   = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
    input  logic [NUM_PORTS*2-1:0]      p_width,
    input  logic [NUM_PORTS-1:0]        p_rstrobe,
    input  logic [NUM_PORTS-1:0]        p_wstrobe,
    output logic [NUM_PORTS-1:0]        p_complete,
    output logic [DATA_W-1:0]           p_rdata,
    output logic [NUM_PORTS-1:0]        p_err,
    output logic                        ram_cs,
    output logic                        ram_we,
    output logic [1:0]                  ram_width,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    input  logic [DATA_W-1:0]           ram_rdata
);

    localparam int GRANT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("WAIT_STATES must be in 0..15");
    end
    if (NUM_BYTES < 1) begin : g_bad_bytes
        $error("NUM_BYTES must be positive");
    end

    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] is_write;
    logic [ADDR_W-1:0]    req_addr  [NUM_PORTS];
    logic [DATA_W-1:0]    req_wdata [NUM_PORTS];
    logic [1:0]           req_width [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
        mem_req_slot #(
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .rstrobe  (p_rstrobe[g]),
            .wstrobe  (p_wstrobe[g]),
            .addr     (p_addr[g*ADDR_W +: ADDR_W]),
            .wdata    (p_wdata[g*DATA_W +: DATA_W]),
            .width    (p_width[g*2 +: 2]),
            .clear    (p_complete[g]),
            .pending  (pending[g]),
            .is_write (is_write[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_width(req_width[g])
        );
    end

    mem_state_t             state;
    logic [GRANT_W-1:0]     grant;
    logic [GRANT_W-1:0]     grant_next;
    logic                   found;
    logic                   oob_next;
    logic                   oob_q;
    logic                   rd_valid;
    logic [WAIT_CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0]      rdata_q;
    logic [DATA_W-1:0]      resp_data;

    always_comb begin
        grant_next = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (pending[i] && !found) begin
                grant_next = GRANT_W'(i);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef MEMCTRL_BOUNDS_CHK_EN
        oob_next = (req_addr[grant_next] >= ADDR_W'(NUM_BYTES));
`else
        oob_next = 1'b0;
`endif
    end

`ifdef MEMCTRL_BOUNDS_CHK_EN
    logic [NUM_PORTS-1:0] err_q;
    assign p_err = err_q;
`else
    assign p_err = '0;
`endif

    // RAM data arrives one cycle after the access, i.e. in RESP, so the completing
    // read is forwarded straight from ram_rdata and rdata_q holds it afterwards.
    always_comb begin
        resp_data = rdata_q;
        if (rd_valid) begin
            resp_data = ram_rdata;
        end else if (oob_q) begin
            resp_data = '0;
        end
    end

    assign p_rdata = (state == ST_RESP) ? resp_data : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            wait_cnt   <= '0;
            oob_q      <= 1'b0;
            rd_valid   <= 1'b0;
            rdata_q    <= '0;
            p_complete <= '0;
            ram_cs     <= 1'b0;
            ram_we     <= 1'b0;
            ram_width  <= WIDTH_64;
            ram_addr   <= '0;
            ram_wdata  <= '0;
`ifdef MEMCTRL_BOUNDS_CHK_EN
            err_q      <= '0;
`endif
        end else begin
            p_complete <= '0;
`ifdef MEMCTRL_BOUNDS_CHK_EN
            err_q      <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        grant     <= grant_next;
                        wait_cnt  <= WAIT_CNT_W'(WAIT_STATES);
                        oob_q     <= oob_next;
                        rd_valid  <= !is_write[grant_next] && !oob_next;
                        ram_cs    <= !oob_next;
                        ram_we    <= is_write[grant_next] && !oob_next;
                        ram_width <= is_write[grant_next] ? req_width[grant_next] : WIDTH_64;
                        ram_addr  <= req_addr[grant_next];
                        ram_wdata <= req_wdata[grant_next];
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        ram_cs            <= 1'b0;
                        ram_we            <= 1'b0;
                        p_complete[grant] <= 1'b1;
`ifdef MEMCTRL_BOUNDS_CHK_EN
                        err_q[grant]      <= oob_q;
`endif
                        state             <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    rdata_q <= resp_data;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_port_ctrl;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int NP = 2;
    localparam int RAND_CYC = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NP*AW-1:0] p_addr, w_p_addr;
    logic [NP*DW-1:0] p_wdata, w_p_wdata;
    logic [NP*2-1:0]  p_width, w_p_width;
    logic [NP-1:0]    p_rstrobe, p_wstrobe, w_p_rstrobe, w_p_wstrobe;
    logic [NP-1:0]    p_complete, p_err, w_p_complete, w_p_err;
    logic [DW-1:0]    p_rdata, w_p_rdata;
    logic             ram_cs, ram_we, w_ram_cs, w_ram_we;
    logic [1:0]       ram_width, w_ram_width;
    logic [AW-1:0]    ram_addr, w_ram_addr;
    logic [DW-1:0]    ram_wdata, w_ram_wdata, ram_rdata, w_ram_rdata;

    mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_PORTS(NP), .WAIT_STATES(0), .NUM_BYTES(256)) dut (
        .clk(clk), .rst(rst), .p_addr(p_addr), .p_wdata(p_wdata), .p_width(p_width),
        .p_rstrobe(p_rstrobe), .p_wstrobe(p_wstrobe), .p_complete(p_complete),
        .p_rdata(p_rdata), .p_err(p_err), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_width(ram_width), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_PORTS(NP), .WAIT_STATES(3), .NUM_BYTES(256)) dut_ws (
        .clk(clk), .rst(rst), .p_addr(w_p_addr), .p_wdata(w_p_wdata), .p_width(w_p_width),
        .p_rstrobe(w_p_rstrobe), .p_wstrobe(w_p_wstrobe), .p_complete(w_p_complete),
        .p_rdata(w_p_rdata), .p_err(w_p_err), .ram_cs(w_ram_cs), .ram_we(w_ram_we),
        .ram_width(w_ram_width), .ram_addr(w_ram_addr), .ram_wdata(w_ram_wdata), .ram_rdata(w_ram_rdata)
    );

    // Byte-lane merge of a write of the given width into the low bytes of a word.
    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [1:0] w);
        int nbytes;
        logic [63:0] mask;
        nbytes = 8 >> w;
        mask = (nbytes == 8) ? '1 : ((64'd1 << (nbytes * 8)) - 64'd1);
        return (old & ~mask) | (nw & mask);
    endfunction

    logic [63:0] mem0 [256];
    logic [63:0] mem1 [256];
    logic [63:0] ref_mem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr;
    logic [63:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) begin
            mem0[pre_addr] <= pre_data;
            mem1[pre_addr] <= pre_data;
        end else begin
            if (ram_cs) begin
                if (ram_we) mem0[ram_addr[7:0]] <= merge(mem0[ram_addr[7:0]], ram_wdata, ram_width);
                else        ram_rdata <= mem0[ram_addr[7:0]];
            end
            if (w_ram_cs) begin
                if (w_ram_we) mem1[w_ram_addr[7:0]] <= merge(mem1[w_ram_addr[7:0]], w_ram_wdata, w_ram_width);
                else          w_ram_rdata <= mem1[w_ram_addr[7:0]];
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [63:0] d);
        pre_en = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Strobe one request in the current cycle and wait (bounded) for its completion.
    task automatic run_single(input int port, input bit wr, input bit both, input logic [63:0] addr,
                              input logic [63:0] data, input logic [1:0] width,
                              output int lat, output logic [NP-1:0] cmp, output logic [63:0] rd,
                              output logic [NP-1:0] err, output bit saw_we, output bit saw_cs);
        lat = -1; cmp = '0; rd = '0; err = '0; saw_we = 1'b0; saw_cs = 1'b0;
        p_addr[port*AW +: AW]  = addr;
        p_wdata[port*DW +: DW] = data;
        p_width[port*2 +: 2]   = width;
        p_wstrobe[port] = wr;
        p_rstrobe[port] = !wr || both;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            p_rstrobe = '0;
            p_wstrobe = '0;
            if (ram_we) saw_we = 1'b1;
            if (ram_cs) saw_cs = 1'b1;
            if (p_complete != '0) begin
                lat = c; cmp = p_complete; rd = p_rdata; err = p_err;
                break;
            end
        end
    endtask

    typedef struct {
        int          port;
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  width;
        logic [63:0] exp_rd;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [1:0]  width;
    } req_t;

    vec_t vecs [10];

    initial begin
        int lat, c0, c1, n0, n1, cs_cnt;
        logic [NP-1:0] cmp, err, exp_c;
        logic [63:0] rd, last_rd, a, d;
        logic [1:0] w;
        bit saw_we, saw_cs, exp_cs, exp_we, rs, ws, busy;
        req_t slot_q [NP];
        bit pend [NP];
        int cur, g_t, d_t, free_at;

        vecs[0] = '{0, 1'b0, 64'h10, 64'h0,                  2'd0, 64'hDEADBEEF};
        vecs[1] = '{1, 1'b1, 64'h30, 64'h0123456789ABCDEF,   2'd0, 64'hDEADBEEF};
        vecs[2] = '{1, 1'b0, 64'h30, 64'h0,                  2'd0, 64'h0123456789ABCDEF};
        vecs[3] = '{0, 1'b1, 64'h30, 64'hFFFFFFFFFFFFFFAA,   2'd3, 64'h0123456789ABCDEF};
        vecs[4] = '{1, 1'b0, 64'h30, 64'h0,                  2'd0, 64'h0123456789ABCDAA};
        vecs[5] = '{0, 1'b1, 64'h30, 64'h1111111122225555,   2'd2, 64'h0123456789ABCDAA};
        vecs[6] = '{0, 1'b0, 64'h30, 64'h0,                  2'd0, 64'h0123456789AB5555};
        vecs[7] = '{1, 1'b1, 64'h30, 64'h99999999CAFEF00D,   2'd1, 64'h0123456789AB5555};
        vecs[8] = '{1, 1'b0, 64'h30, 64'h0,                  2'd0, 64'h01234567CAFEF00D};
        vecs[9] = '{0, 1'b0, 64'h10, 64'h0,                  2'd0, 64'hDEADBEEF};

        rst = 1'b1;
        p_addr = '0; p_wdata = '0; p_width = '0; p_rstrobe = '0; p_wstrobe = '0;
        w_p_addr = '0; w_p_wdata = '0; w_p_width = '0; w_p_rstrobe = '0; w_p_wstrobe = '0;
        repeat (3) @(negedge clk);
        check("reset ctrl", 64'({p_complete, p_err, ram_cs, ram_we, ram_width}), 64'd0);
        check("reset p_rdata", p_rdata, 64'd0);
        check("reset ram_addr", ram_addr, 64'd0);
        check("reset ram_wdata", ram_wdata, 64'd0);
        rst = 1'b0;
        preload(8'h10, 64'hDEADBEEF);
        for (int i = 0; i < 16; i++) preload(8'(8'h80 + i), {32'hA5A50000, 32'(i * 7919)});

        // Directed single transactions, no contention
        for (int i = 0; i < 10; i++) begin
            run_single(vecs[i].port, vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].width,
                       lat, cmp, rd, err, saw_we, saw_cs);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd3);
            check($sformatf("vec%0d complete", i), 64'(cmp), 64'(1 << vecs[i].port));
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d ram_we", i), 64'(saw_we), 64'(vecs[i].wr));
        end

        // Contention: both ports write in the same cycle
        p_addr = {64'h28, 64'h20};
        p_wdata = {64'h22, 64'h11};
        p_width = '0;
        p_wstrobe = 2'b11;
        c0 = -1; c1 = -1; n0 = 0; n1 = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            p_wstrobe = '0;
            if (p_complete[0]) begin c0 = c; n0++; end
            if (p_complete[1]) begin c1 = c; n1++; end
        end
        check("contend p0 cycle", 64'(c0), 64'd3);
        check("contend p1 cycle", 64'(c1), 64'd6);
        check("contend counts", 64'({n0[3:0], n1[3:0]}), 64'h11);
        run_single(0, 1'b0, 1'b0, 64'h20, 64'h0, 2'd0, lat, cmp, rd, err, saw_we, saw_cs);
        check("contend rd 0x20", rd, 64'h11);
        run_single(1, 1'b0, 1'b0, 64'h28, 64'h0, 2'd0, lat, cmp, rd, err, saw_we, saw_cs);
        check("contend rd 0x28", rd, 64'h22);

        // Duplicate strobes on port 1 while pending; later strobes carry a different address
        p_addr[AW +: AW] = 64'h20;
        p_rstrobe[1] = 1'b1;
        n1 = 0; rd = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            p_addr[AW +: AW] = 64'h28;
            p_rstrobe[1] = (c <= 2);
            if (p_complete[1]) begin n1++; rd = p_rdata; end
        end
        check("dup completions", 64'(n1), 64'd1);
        check("dup rdata", rd, 64'h11);

        // Simultaneous read and write strobe: only the write is taken
        run_single(0, 1'b1, 1'b1, 64'h40, 64'h77, 2'd0, lat, cmp, rd, err, saw_we, saw_cs);
        check("both latency", 64'(lat), 64'd3);
        check("both wrote", 64'(saw_we), 64'd1);
        n0 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (p_complete != '0) n0++;
        end
        check("both extra completions", 64'(n0), 64'd0);
        run_single(0, 1'b0, 1'b0, 64'h40, 64'h0, 2'd0, lat, cmp, rd, err, saw_we, saw_cs);
        check("both readback", rd, 64'h77);

        // Reset while in ACCESS
        p_addr[AW-1:0] = 64'h48;
        p_wdata[DW-1:0] = 64'h55;
        p_wstrobe[0] = 1'b1;
        @(negedge clk);
        p_wstrobe = '0;
        @(negedge clk);
        check("midrst in access", 64'(ram_cs), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst ctrl", 64'({p_complete, p_err, ram_cs, ram_we, ram_width}), 64'd0);
        check("midrst p_rdata", p_rdata, 64'd0);
        check("midrst ram_addr", ram_addr, 64'd0);
        check("midrst ram_wdata", ram_wdata, 64'd0);
        rst = 1'b0;
        n0 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (p_complete != '0 || ram_cs) n0++;
        end
        check("midrst abandoned", 64'(n0), 64'd0);
        run_single(1, 1'b0, 1'b0, 64'h10, 64'h0, 2'd0, lat, cmp, rd, err, saw_we, saw_cs);
        check("midrst new latency", 64'(lat), 64'd3);
        check("midrst new rdata", rd, 64'hDEADBEEF);

        // Wait states on the WAIT_STATES=3 instance
        w_p_addr[AW-1:0] = 64'h10;
        w_p_rstrobe[0] = 1'b1;
        cs_cnt = 0; c0 = -1; rd = '0; saw_we = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            w_p_rstrobe = '0;
            if (w_ram_cs) cs_cnt++;
            if (w_ram_we) saw_we = 1'b1;
            if (w_p_complete[0] && c0 < 0) begin c0 = c; rd = w_p_rdata; end
        end
        check("ws cs cycles", 64'(cs_cnt), 64'd4);
        check("ws complete cycle", 64'(c0), 64'd6);
        check("ws rdata", rd, 64'hDEADBEEF);
        check("ws no write", 64'(saw_we), 64'd0);

`ifdef MEMCTRL_BOUNDS_CHK_EN
        run_single(0, 1'b0, 1'b0, 64'h100, 64'h0, 2'd0, lat, cmp, rd, err, saw_we, saw_cs);
        check("oob latency", 64'(lat), 64'd3);
        check("oob ram_cs", 64'(saw_cs), 64'd0);
        check("oob err", 64'(err), 64'd1);
        check("oob rdata", rd, 64'd0);
`else
        run_single(0, 1'b0, 1'b0, 64'h110, 64'h0, 2'd0, lat, cmp, rd, err, saw_we, saw_cs);
        check("wrap latency", 64'(lat), 64'd3);
        check("wrap err", 64'(err), 64'd0);
        check("wrap rdata", rd, 64'hDEADBEEF);
`endif

        // Randomized run against the transaction-level model
        run_single(0, 1'b0, 1'b0, 64'h80, 64'h0, 2'd0, lat, cmp, rd, err, saw_we, saw_cs);
        check("rnd sync rdata", rd, ref_mem[8'h80]);
        last_rd = ref_mem[8'h80];
        @(negedge clk);
        busy = 1'b0; cur = 0; g_t = 0; d_t = 0; free_at = 0;
        for (int p = 0; p < NP; p++) pend[p] = 1'b0;
        for (int t = 0; t < RAND_CYC + 12; t++) begin
            exp_c = '0;
            exp_cs = busy && (t > g_t) && (t < d_t);
            exp_we = exp_cs && slot_q[cur].wr;
            if (busy && t == d_t) exp_c[cur] = 1'b1;
            check($sformatf("rnd t%0d complete", t), 64'(p_complete), 64'(exp_c));
            check($sformatf("rnd t%0d cs/we/err", t), 64'({ram_cs, ram_we, p_err}), 64'({exp_cs, exp_we, 2'b00}));
            if (exp_cs) begin
                check($sformatf("rnd t%0d ram_addr", t), ram_addr, slot_q[cur].addr);
                check($sformatf("rnd t%0d ram_width", t), 64'(ram_width), 64'(slot_q[cur].wr ? slot_q[cur].width : 2'd0));
            end
            if (busy && t == d_t) begin
                if (slot_q[cur].wr)
                    ref_mem[slot_q[cur].addr[7:0]] = merge(ref_mem[slot_q[cur].addr[7:0]], slot_q[cur].data, slot_q[cur].width);
                else
                    last_rd = ref_mem[slot_q[cur].addr[7:0]];
                check($sformatf("rnd t%0d rdata", t), p_rdata, last_rd);
                pend[cur] = 1'b0;
                busy = 1'b0;
            end
            if (!busy && t >= free_at) begin
                for (int p = 0; p < NP; p++) begin
                    if (pend[p] && !busy) begin
                        busy = 1'b1; cur = p; g_t = t; d_t = t + 2; free_at = t + 3;
                    end
                end
            end
            p_rstrobe = '0;
            p_wstrobe = '0;
            if (t < RAND_CYC) begin
                for (int p = 0; p < NP; p++) begin
                    rs = ($urandom_range(0, 3) == 0);
                    ws = ($urandom_range(0, 3) == 0);
                    a = 64'h80 + 64'($urandom_range(0, 15));
                    d = {$urandom, $urandom};
                    w = 2'($urandom_range(0, 3));
                    p_addr[p*AW +: AW] = a;
                    p_wdata[p*DW +: DW] = d;
                    p_width[p*2 +: 2] = w;
                    p_rstrobe[p] = rs;
                    p_wstrobe[p] = ws;
                    if ((rs || ws) && !pend[p]) begin
                        pend[p] = 1'b1;
                        slot_q[p].wr = ws;
                        slot_q[p].addr = a;
                        slot_q[p].data = d;
                        slot_q[p].width = w;
                    end
                end
            end
            @(negedge clk);
        end
        check("rnd drained", 64'({busy, pend[0], pend[1]}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Parametrised memory-port controller that arbitrates NUM_PORTS strobe-style requesters (CPU dmem, debug, future DMA) onto one synchronous RAM port.
- Generates per-port one-cycle completion pulses with configurable wait states.
- Replaces the hard-wired debug address/data muxing and the single-flop dmem_cycle_complete logic.
- Sits between the pipeline/debug_control and each ram instance; one instance serves imem, another serves dmem.

Parameters:
- ADDR_W, 64, address width per port
- DATA_W, 64, data width
- NUM_PORTS, 2, number of requesters; port 0 has highest priority
- WAIT_STATES, 0, extra cycles the RAM access is held (0..15)
- NUM_BYTES, 256, RAM size in bytes; used only by the bounds check

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- p_addr  in  NUM_PORTS*ADDR_W  request address, per port, packed with port 0 at the LSBs
- p_wdata  in  NUM_PORTS*DATA_W  write data, per port
- p_width  in  NUM_PORTS*2  write width, per port: 0=64b, 1=32b, 2=16b, 3=8b
- p_rstrobe  in  NUM_PORTS  read request pulse
- p_wstrobe  in  NUM_PORTS  write request pulse
- p_complete  out  NUM_PORTS  one-cycle completion pulse
- p_rdata  out  DATA_W  read data; shared by all ports; valid only while some p_complete bit is high
- p_err  out  NUM_PORTS  error flag; meaningful only when MEMCTRL_BOUNDS_CHK_EN is defined
- ram_cs, ram_we  out  1  RAM chip select and write enable
- ram_width  out  2  RAM write width, same encoding as p_width
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; 1-cycle synchronous read latency

Behaviour:
- Reset, synchronous on rst:
  - FSM goes to IDLE.
  - All pending bits clear. In-flight access abandoned; no completion pulse for it.
  - All outputs go to 0: p_complete, p_err, p_rdata, ram_cs, ram_we, ram_width, ram_addr, ram_wdata.
- Request slots:
  - Each port has a slot holding pending, is_write, addr, wdata and width.
  - A strobe captures the request at the clock edge.
  - If rstrobe and wstrobe arrive in the same cycle, the write is taken and the read is dropped.
  - A strobe on a port whose slot is already pending is ignored.
  - A strobe in the same cycle as that port's completion pulse is accepted.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
  - IDLE: if any slot is pending, grant the lowest-index pending port. ram_* signals are registered from the slot; go to ACCESS.
  - ACCESS: ram_cs=1; ram_we=is_write. Stays for 1+WAIT_STATES cycles, counted by the wait counter. A write is re-asserted each cycle; this is idempotent. Then go to RESP.
  - RESP: ram_cs and ram_we drop. p_complete[grant] pulses for exactly one cycle. For reads, p_rdata is registered from ram_rdata and is valid in that cycle. The slot's pending bit clears. Next state is IDLE.
- Latency:
  - Strobe in cycle 0 with no contention gives complete in cycle 3+WAIT_STATES.
  - Throughput is one access per 3+WAIT_STATES cycles.
- Priority is fixed and non-preemptive. A grant is held until RESP finishes.
- p_rdata holds its value between completions; reads return ram_rdata unmodified.
- Writes pass the width to ram_width; the RAM applies width to the low bytes. Reads always drive ram_width=0.

Optional Feature:
- Macro: MEMCTRL_BOUNDS_CHK_EN.
- Defined:
  - A granted request with addr >= NUM_BYTES is flagged out of range.
  - It skips the RAM: ram_cs stays 0 during ACCESS.
  - It still completes on the normal timeline, with p_err[grant]=1 alongside p_complete and p_rdata=0.
- Undefined:
  - p_err is tied to 0.
  - The address goes to the RAM unchecked; the RAM wraps the address.

Decomposition:
- Shared package mem_pkg:
  - width-encoding constants: WIDTH_64, WIDTH_32, WIDTH_16, WIDTH_8
  - FSM state enum: ST_IDLE, ST_ACCESS, ST_RESP
  - wait-counter width constant: 4
- Natural sub-module: mem_req_slot, one request latch per port, generated NUM_PORTS times.

Test Plan:
- Single read, WAIT_STATES=0: preload RAM[0x10]=0xDEADBEEF, port 0 rstrobe with addr 0x10 in cycle 0 -> p_complete[0] in cycle 3, p_rdata=0xDEADBEEF, ram_we never high.
- Contention: ports 0 and 1 both strobe writes in cycle 0 (0x20<-0x11, 0x28<-0x22) -> port 0 completes in cycle 3, port 1 in cycle 6; readback gives 0x11 and 0x22.
- Wait states, WAIT_STATES=3: read -> ram_cs high for 4 cycles, complete in cycle 6.
- Duplicate and simultaneous strobes:
  - Port 1 re-strobes while pending -> exactly one completion.
  - Port 0 asserts rstrobe and wstrobe together -> write performed, single completion.
- Reset mid-ACCESS: rst asserted during ACCESS -> no p_complete, all outputs 0 next cycle, pending cleared; a new request afterwards completes normally.
- Bounds check, with MEMCTRL_BOUNDS_CHK_EN defined: read of 0x100 with NUM_BYTES=256 -> ram_cs stays 0, p_complete[0] and p_err[0] high in cycle 3, p_rdata=0.
